wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
// PURPOSE
//  Write-back end of the MEM->WB interface. Captures the MEM stage outputs (WB control, read data,
//  ALU result, dest reg) into the MEM/WB pipeline register. Selects the write-back value and commits
//  it to a 32-entry register file. Also serves the ID stage's two combinational read ports, with
//  same-cycle write bypass. Exposes the WB write for the EX forwarding unit.
// PARAMETERS
//  DATA_W   32  data width of register file and datapath
//  ADDR_W   5   register address width
//  NUM_REGS 32  number of architectural registers (2**ADDR_W)
//  CNT_W    16  width of commit counter
// PORTS
//  Clk            in   1       rising-edge clock
//  Rst            in   1       asynchronous, active-high reset
//  MEM_WB         in   2       WB control from MEM: [1]=RegWrite, [0]=MemtoReg
//  MEM_ReadData   in   DATA_W  data-memory read value
//  MEM_ALUResult  in   DATA_W  ALU result passed through MEM
//  MEM_WriteReg   in   ADDR_W  destination register
//  Stall          in   1       hold MEM/WB register; suppress commit
//  Flush          in   1       load a bubble into MEM/WB register
//  ID_ReadReg1    in   ADDR_W  read port 1 address
//  ID_ReadReg2    in   ADDR_W  read port 2 address
//  ID_ReadData1   out  DATA_W  read port 1 data (combinational)
//  ID_ReadData2   out  DATA_W  read port 2 data (combinational)
//  WB_RegWrite    out  1       registered RegWrite of the instruction in WB
//  WB_WriteReg    out  ADDR_W  registered destination of the instruction in WB
//  WB_WriteData   out  DATA_W  registered write-back value
//  CommitCount    out  CNT_W   number of committed register writes
// BEHAVIOUR
//  Reset (Rst=1, async, no clock edge needed):
//   - All register-file entries = 0.
//   - WB_RegWrite = 0, WB_WriteReg = 0, WB_WriteData = 0.
//   - Internal MemtoReg flop = 0; CommitCount = 0.
//   - Rst may assert mid-operation; any pending commit is dropped.
//  MEM/WB capture, on posedge Clk, priority order:
//   1. Flush: WB_RegWrite = 0, WB_WriteReg = 0, WB_WriteData = 0 (bubble). Flush overrides Stall.
//   2. Stall: all MEM/WB fields hold their value.
//   3. Otherwise load: WB_RegWrite = MEM_WB[1], WB_WriteReg = MEM_WriteReg,
//      WB_WriteData = MEM_WB[0] ? MEM_ReadData : MEM_ALUResult.
//  Commit: commit = WB_RegWrite & (WB_WriteReg != 0) & ~Stall.
//   - On posedge Clk with commit=1: RF[WB_WriteReg] = WB_WriteData; CommitCount += 1.
//   - Counter wraps modulo 2**CNT_W.
//   - A stalled instruction commits exactly once, on the first edge with Stall=0.
//   - Commit of the current WB content and Flush/load of the next occur on the same edge.
//  Latency:
//   - MEM inputs visible on WB_* outputs 1 cycle after the capture edge.
//   - RF updated at the next unstalled edge.
//  Register 0:
//   - Hardwired to 0; reads always return 0.
//   - Writes to register 0 are discarded and not counted.
//  Read ports (both identical, combinational):
//   - addr == 0 -> 0.
//   - else if WB_RegWrite & (WB_WriteReg == addr) -> WB_WriteData (bypass; applies even while
//     stalled, because the value is the youngest for that register).
//   - else -> RF[addr].
//   - Both ports may read the same address.
// TESTING
//  1. Rst pulse; then MEM_WB=2'b10, ALU=32'h1234, WriteReg=5 -> edge 1: WB_WriteData=32'h1234;
//     during that cycle ID_ReadReg1=5 reads 32'h1234 (bypass); after edge 2 RF[5]=32'h1234, CommitCount=1.
//  2. MEM_WB=2'b11, ReadData=32'hDEADBEEF, ALU=32'h1, WriteReg=7 -> RF[7]=32'hDEADBEEF;
//     same stimulus with MEM_WB=2'b01 -> RF[7] unchanged, CommitCount unchanged.
//  3. MEM_WB=2'b10, WriteReg=0, ALU=32'hFFFF_FFFF -> ID_ReadData1/2 for addr 0 stay 0; CommitCount unchanged.
//  4. Load a write to reg 9, hold Stall=1 for 3 cycles, then release -> WB_* hold throughout;
//     CommitCount +1 exactly once; with Stall=1 and Flush=1 together -> next edge WB_RegWrite=0, WB_WriteReg=0.
//  5. Back-to-back writes to regs 3,4,3 (values 1,2,3) -> final RF[3]=3, RF[4]=2; both ports reading
//     reg 3 mid-sequence return the newest value.
//  6. 65536 consecutive commits -> CommitCount wraps to 0; assert Rst between clock edges ->
//     all reads 0 and CommitCount 0 immediately.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back select, 32-entry
// register file with two combinational read ports (same-cycle WB bypass),
// and a counter of committed register writes.
module wb_regfile_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [1:0]        MEM_WB,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic [ADDR_W-1:0] MEM_WriteReg,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] ID_ReadReg1,
  input  logic [ADDR_W-1:0] ID_ReadReg2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic              WB_RegWrite,
  output logic [ADDR_W-1:0] WB_WriteReg,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [CNT_W-1:0]  CommitCount
);

  // Write-back value selection: MemtoReg picks memory data over ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              memtoreg,
    input logic [DATA_W-1:0] read_data,
    input logic [DATA_W-1:0] alu_result
  );
    return memtoreg ? read_data : alu_result;
  endfunction

  // Read port resolution: r0 is zero, the WB instruction is the youngest
  // producer for its register (even while stalled), else the array value.
  function automatic logic [DATA_W-1:0] read_resolve(
    input logic [ADDR_W-1:0] addr,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (addr == '0) begin
      return '0;
    end else if (wb_we && (wb_addr == addr)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  // MEM-side (stage p0) values entering the pipeline register.
  logic              vld_p0;
  logic [ADDR_W-1:0] writereg_p0;
  logic [DATA_W-1:0] writedata_p0;

  // MEM/WB pipeline register (stage p1).
  logic              vld_p1;
  logic [ADDR_W-1:0] writereg_p1;
  logic [DATA_W-1:0] writedata_p1;

  logic              commit;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rf [NUM_REGS];

  // ---- stage p0: MEM outputs, write-back value chosen before capture ----
  // Decode MEM control and pick the write-back value ahead of the register.
  always_comb begin
    vld_p0       = MEM_WB[1];
    writereg_p0  = MEM_WriteReg;
    writedata_p0 = wb_select(MEM_WB[0], MEM_ReadData, MEM_ALUResult);
  end

  // ---- stage p1: MEM/WB register ----
  // Capture with Flush > Stall > load priority; Flush inserts a bubble.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_p1       <= 1'b0;
      writereg_p1  <= '0;
      writedata_p1 <= '0;
    end else if (Flush) begin
      vld_p1       <= 1'b0;
      writereg_p1  <= '0;
      writedata_p1 <= '0;
    end else if (!Stall) begin
      vld_p1       <= vld_p0;
      writereg_p1  <= writereg_p0;
      writedata_p1 <= writedata_p0;
    end
  end

  // A WB instruction commits on the first unstalled edge; r0 writes are dropped.
  always_comb begin
    commit = vld_p1 && (writereg_p1 != '0) && !Stall;
  end

  // ---- commit: register file and commit counter ----
  // Register array update; entry 0 is never written so it stays zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (commit) begin
      rf[writereg_p1] <= writedata_p1;
    end
  end

  // Count committed writes, wrapping naturally at 2**CNT_W.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (commit) begin
      count <= count + CNT_W'(1);
    end
  end

  // Combinational read ports with WB bypass.
  always_comb begin
    ID_ReadData1 = read_resolve(ID_ReadReg1, vld_p1, writereg_p1, writedata_p1, rf[ID_ReadReg1]);
    ID_ReadData2 = read_resolve(ID_ReadReg2, vld_p1, writereg_p1, writedata_p1, rf[ID_ReadReg2]);
  end

  // Expose the WB write for forwarding and the commit count.
  always_comb begin
    WB_RegWrite  = vld_p1;
    WB_WriteReg  = writereg_p1;
    WB_WriteData = writedata_p1;
    CommitCount  = count;
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: a vector table for single
// write-back transactions plus hand-written stall/flush, back-to-back,
// counter-wrap and mid-cycle reset sequences.
module tb_wb_regfile_stage;

  logic        Clk;
  logic        Rst;
  logic [1:0]  MEM_WB;
  logic [31:0] MEM_ReadData;
  logic [31:0] MEM_ALUResult;
  logic [4:0]  MEM_WriteReg;
  logic        Stall;
  logic        Flush;
  logic [4:0]  ID_ReadReg1;
  logic [4:0]  ID_ReadReg2;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [15:0] CommitCount;

  int tests;
  int fails;

  wb_regfile_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .MEM_WB       (MEM_WB),
    .MEM_ReadData (MEM_ReadData),
    .MEM_ALUResult(MEM_ALUResult),
    .MEM_WriteReg (MEM_WriteReg),
    .Stall        (Stall),
    .Flush        (Flush),
    .ID_ReadReg1  (ID_ReadReg1),
    .ID_ReadReg2  (ID_ReadReg2),
    .ID_ReadData1 (ID_ReadData1),
    .ID_ReadData2 (ID_ReadData2),
    .WB_RegWrite  (WB_RegWrite),
    .WB_WriteReg  (WB_WriteReg),
    .WB_WriteData (WB_WriteData),
    .CommitCount  (CommitCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  mem_wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_bypass;
    logic [31:0] exp_rf;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wreg);
    MEM_WB = wb;
    MEM_ReadData = rd;
    MEM_ALUResult = alu;
    MEM_WriteReg = wreg;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Rst = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    ID_ReadReg1 = 5'd5;
    ID_ReadReg2 = 5'd7;

    vecs[0] = '{2'b10, 32'h0000_0000, 32'h0000_1234, 5'd5, 1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 16'd1};
    vecs[1] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd2};
    vecs[2] = '{2'b01, 32'h0BAD_F00D, 32'h0000_0001, 5'd7, 1'b0, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd2};
    vecs[3] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 16'd2};
    vecs[4] = '{2'b00, 32'h0000_0000, 32'h0000_0055, 5'd9, 1'b0, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000, 16'd2};

    #12;
    check("reset_we", {31'd0, WB_RegWrite}, 32'd0);
    check("reset_wreg", {27'd0, WB_WriteReg}, 32'd0);
    check("reset_wdata", WB_WriteData, 32'd0);
    check("reset_cnt", {16'd0, CommitCount}, 32'd0);
    check("reset_rd1", ID_ReadData1, 32'd0);
    Rst = 1'b0;

    // Table: load one transaction, check WB and bypass, then a bubble and check the array.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].mem_wb, vecs[i].rdata, vecs[i].alu, vecs[i].wreg);
      ID_ReadReg1 = vecs[i].wreg;
      ID_ReadReg2 = vecs[i].wreg;
      tick();
      check($sformatf("v%0d_we", i), {31'd0, WB_RegWrite}, {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d_wreg", i), {27'd0, WB_WriteReg}, {27'd0, vecs[i].wreg});
      check($sformatf("v%0d_wdata", i), WB_WriteData, vecs[i].exp_wdata);
      check($sformatf("v%0d_bypass", i), ID_ReadData1, vecs[i].exp_bypass);
      drive(2'b00, 32'h0, 32'h0, 5'd0);
      tick();
      check($sformatf("v%0d_rf", i), ID_ReadData2, vecs[i].exp_rf);
      check($sformatf("v%0d_cnt", i), {16'd0, CommitCount}, {16'd0, vecs[i].exp_cnt});
    end

    // Stall holds the WB register and delays the commit to the release edge.
    drive(2'b10, 32'h0, 32'h0000_A5A5, 5'd9);
    ID_ReadReg1 = 5'd9;
    tick();
    Stall = 1'b1;
    drive(2'b10, 32'h0, 32'h0000_0077, 5'd10);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_we", c), {31'd0, WB_RegWrite}, 32'd1);
      check($sformatf("stall%0d_wreg", c), {27'd0, WB_WriteReg}, 32'd9);
      check($sformatf("stall%0d_wdata", c), WB_WriteData, 32'h0000_A5A5);
      check($sformatf("stall%0d_cnt", c), {16'd0, CommitCount}, 32'd2);
      check($sformatf("stall%0d_bypass", c), ID_ReadData1, 32'h0000_A5A5);
    end
    Stall = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    check("release_cnt", {16'd0, CommitCount}, 32'd3);
    check("release_rf9", ID_ReadData1, 32'h0000_A5A5);
    tick();
    check("release_cnt_once", {16'd0, CommitCount}, 32'd3);

    // Flush beats Stall; the stalled write never commits.
    drive(2'b10, 32'h0, 32'h0000_0011, 5'd11);
    ID_ReadReg1 = 5'd11;
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    Stall = 1'b1;
    Flush = 1'b1;
    tick();
    Stall = 1'b0;
    Flush = 1'b0;
    check("flush_we", {31'd0, WB_RegWrite}, 32'd0);
    check("flush_wreg", {27'd0, WB_WriteReg}, 32'd0);
    check("flush_wdata", WB_WriteData, 32'd0);
    check("flush_cnt", {16'd0, CommitCount}, 32'd3);
    check("flush_rf11", ID_ReadData1, 32'd0);

    // Back-to-back writes 3<-1, 4<-2, 3<-3.
    ID_ReadReg1 = 5'd3;
    ID_ReadReg2 = 5'd3;
    drive(2'b10, 32'h0, 32'd1, 5'd3);
    tick();
    drive(2'b10, 32'h0, 32'd2, 5'd4);
    tick();
    check("b2b_mid_rd1", ID_ReadData1, 32'd1);
    drive(2'b10, 32'h0, 32'd3, 5'd3);
    tick();
    check("b2b_byp_rd1", ID_ReadData1, 32'd3);
    check("b2b_byp_rd2", ID_ReadData2, 32'd3);
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    ID_ReadReg2 = 5'd4;
    #1;
    check("b2b_rf3", ID_ReadData1, 32'd3);
    check("b2b_rf4", ID_ReadData2, 32'd2);
    check("b2b_cnt", {16'd0, CommitCount}, 32'd6);

    // Counter wrap: from reset, 65536 commits bring the count back to 0.
    Rst = 1'b1;
    #1;
    Rst = 1'b0;
    check("rst2_cnt", {16'd0, CommitCount}, 32'd0);
    drive(2'b10, 32'h0, 32'h0000_00AB, 5'd1);
    tick();
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    check("wrap_ffff", {16'd0, CommitCount}, 32'h0000_FFFF);
    tick();
    check("wrap_zero", {16'd0, CommitCount}, 32'd0);
    tick();
    tick();
    check("wrap_two", {16'd0, CommitCount}, 32'd2);

    // Asynchronous reset between edges clears everything at once.
    ID_ReadReg1 = 5'd1;
    ID_ReadReg2 = 5'd3;
    #2;
    Rst = 1'b1;
    #1;
    check("arst_rd1", ID_ReadData1, 32'd0);
    check("arst_rd2", ID_ReadData2, 32'd0);
    check("arst_cnt", {16'd0, CommitCount}, 32'd0);
    check("arst_we", {31'd0, WB_RegWrite}, 32'd0);
    tick();
    check("arst_hold_cnt", {16'd0, CommitCount}, 32'd0);
    Rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
